ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
- Front-end sequencer sitting directly upstream of the single-port synchronous RAM (ADR/DATA/MS geometry, registered read data, CS/WRITE/READ strobes).
- Converts a valid/ready request stream (read or write) into correctly timed RAM strobes and returns read data on a valid/ready response channel.
- After reset it runs a clear sequence that fills every location with INIT_VAL before accepting traffic.

Parameters:
- ADR, 10, address width; matches RAM.
- DATA, 8, data width; matches RAM.
- MS, 1024, number of implemented words; legal addresses are 0..MS-1, and MS <= 2**ADR.
- INIT_VAL, 0, value written to every location during clear.
- CLEAR_EN, 1, 1 = run the clear sequence after reset; 0 = go straight to RUN.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted on an edge where req_valid && req_ready.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADR  request address.
- req_wdata  input  DATA  write data.
- rsp_valid  output  1  read response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_data  output  DATA  read data.
- rsp_err  output  1  response is for an out-of-range address.
- init_done  output  1  clear finished; stays high until reset.
- mem_cs  output  1  to RAM CS.
- mem_write  output  1  to RAM WRITE.
- mem_read  output  1  to RAM READ.
- mem_addr  output  ADR  to RAM Addr.
- mem_din  output  DATA  to RAM dataIn.
- mem_dout  input  DATA  from RAM dataOut.

Behaviour:
- Reset (rst_n low at an edge) sets:
  - state = CLEAR if CLEAR_EN, else RUN.
  - mem_cs = mem_write = mem_read = 0; mem_addr = 0; mem_din = 0.
  - rsp_valid = 0; rsp_data = 0; rsp_err = 0.
  - init_done = CLEAR_EN ? 0 : 1.
  - Clear counter = 0.
- Reset mid-operation abandons any in-flight read and any pending response, then restarts CLEAR.
- All mem_* outputs are registered. Exactly one of mem_write/mem_read is high whenever mem_cs = 1; all three are low on idle cycles.
- CLEAR state:
  - One write per cycle: mem_cs = 1, mem_write = 1, mem_addr = counter, mem_din = INIT_VAL, for counter 0..MS-1.
  - req_ready = 0 throughout.
  - On the edge that registers address MS-1, move to RUN. init_done rises one cycle later, aligned with the RAM committing the last write.
- RUN state:
  - req_ready = !rd_busy. rd_busy = read in flight (2-stage tracker) OR rsp_valid.
  - Write accepted at edge E: at E, register mem_cs = 1, mem_write = 1, addr, data. The RAM commits at E+1. Back-to-back writes run at one per cycle.
  - Read accepted at edge E: at E, register mem_cs = 1, mem_read = 1, addr. The RAM updates dataOut at E+1. At E+2, capture mem_dout into rsp_data and set rsp_valid = 1. Read latency is 2 cycles.
  - rsp_valid holds with stable rsp_data/rsp_err until rsp_valid && rsp_ready. It clears on that edge, and req_ready returns in the same cycle it clears.
- Out of range (req_addr >= MS, only possible when MS < 2**ADR):
  - Writes are accepted and dropped, with no mem strobe.
  - Reads are accepted with no mem strobe, and return rsp_data = 0, rsp_err = 1 with the same 2-cycle latency.
- Read-after-write to the same address in consecutive accepted requests returns the new data.

Decomposition:
- Package ram_access_pkg holds:
  - State enum {CLEAR, RUN}.
  - Default ADR/DATA/MS constants shared with the RAM instantiation.
- Sub-module ram_clear_seq holds the clear counter and the done flag, with outputs clr_active, clr_addr, clr_last. The top muxes its outputs onto the mem_* registers.

Test Plan:
- Clear: reset, CLEAR_EN=1, MS=1024 -> 1024 consecutive write strobes for addresses 0..1023 with din=0; init_done high 1025 cycles after reset release; req_ready low until then.
- Write/read: write 0xA5 to 0x3FF, then read 0x3FF -> rsp_valid 2 cycles after read acceptance, rsp_data=0xA5, rsp_err=0.
- Backpressure: read 0x010 with rsp_ready=0 for 5 cycles -> rsp_valid and data held stable, req_ready=0; rsp_ready=1 -> rsp_valid drops and req_ready=1 the next cycle.
- Streaming writes: 4 writes to 0..3 on consecutive cycles, no read pending -> 4 consecutive mem_write strobes, req_ready never drops.
- Range check: MS=1000; read 1000 -> rsp_err=1, rsp_data=0, no mem_cs; write 1001 -> no mem_cs.
- Reset mid-read: assert rst_n=0 one cycle after read acceptance -> rsp_valid never rises; CLEAR restarts from address 0.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_access_pkg                                                           |
// | Shared state encoding and default RAM geometry for the access controller |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ram_access_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Geometry of the RAM this controller normally fronts.
   localparam int RAM_ADR  = 10;
   localparam int RAM_DATA = 8;
   localparam int RAM_MS   = 1024;

endpackage
`default_nettype wire

// File: rtl/ram_access_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_access_ctrl_if                                                       |
// | Request/response stream, status and RAM strobe bundle                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ram_access_ctrl_if #(
   parameter int ADR  = ram_access_pkg::RAM_ADR,
   parameter int DATA = ram_access_pkg::RAM_DATA
) ();

   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [ADR-1:0]  req_addr;
   logic [DATA-1:0] req_wdata;

   logic            rsp_valid;
   logic            rsp_ready;
   logic [DATA-1:0] rsp_data;
   logic            rsp_err;

   logic            init_done;

   logic            mem_cs;
   logic            mem_write;
   logic            mem_read;
   logic [ADR-1:0]  mem_addr;
   logic [DATA-1:0] mem_din;
   logic [DATA-1:0] mem_dout;

   // Controller side
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
      output req_ready, rsp_valid, rsp_data, rsp_err, init_done,
             mem_cs, mem_write, mem_read, mem_addr, mem_din
   );

   // Requester plus RAM side
   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
      input  req_ready, rsp_valid, rsp_data, rsp_err, init_done,
             mem_cs, mem_write, mem_read, mem_addr, mem_din
   );

endinterface
`default_nettype wire

// File: rtl/ram_access_ctrl_clear_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_clear_seq                                                            |
// | Post-reset address walker for the RAM clear pass and its done flag       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_clear_seq
   import ram_access_pkg::*;
#(
   parameter int ADR      = RAM_ADR,
   parameter int MS       = RAM_MS,
   parameter int CLEAR_EN = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   output logic           o_clr_active,
   output logic [ADR-1:0] o_clr_addr,
   output logic           o_clr_last,
   output logic           o_done
);

   localparam logic [ADR-1:0] c_LAST_ADDR = ADR'(MS - 1);

   logic           r_active;
   logic [ADR-1:0] r_cnt;
   logic           r_last_d;
   logic           r_done;
   logic           w_last;

   assign w_last = r_active && (r_cnt == c_LAST_ADDR);

   // Done trails the last address by one edge so it coincides with the RAM
   // committing that final write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_active <= (CLEAR_EN != 0);
         r_cnt    <= '0;
         r_last_d <= 1'b0;
         r_done   <= (CLEAR_EN == 0);
      end else begin
         r_last_d <= w_last;
         r_done   <= r_done | r_last_d;
         if (r_active) begin
            r_cnt <= w_last ? '0 : r_cnt + ADR'(1);
            if (w_last) begin
               r_active <= 1'b0;
            end
         end
      end
   end

   assign o_clr_active = r_active;
   assign o_clr_addr   = r_cnt;
   assign o_clr_last   = w_last;
   assign o_done       = r_done;

endmodule
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_access_ctrl                                                          |
// | Sequences read/write requests onto a single-port synchronous RAM         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_access_ctrl
   import ram_access_pkg::*;
#(
   parameter int              ADR      = RAM_ADR,
   parameter int              DATA     = RAM_DATA,
   parameter int              MS       = RAM_MS,
   parameter logic [DATA-1:0] INIT_VAL = '0,
   parameter int              CLEAR_EN = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   ram_access_ctrl_if.slave   bus
);

   localparam logic [ADR:0] c_MS        = (ADR + 1)'(MS);
   localparam state_t       c_RST_STATE = (CLEAR_EN != 0) ? CLEAR : RUN;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            w_clr_active;
   logic [ADR-1:0]  w_clr_addr;
   logic            w_clr_last;
   logic            w_clr_done;

   logic            r_rd_s1;
   logic            r_rd_s2;
   logic            r_err_s1;
   logic            r_err_s2;

   logic            r_rsp_valid;
   logic [DATA-1:0] r_rsp_data;
   logic            r_rsp_err;

   logic            r_mem_cs;
   logic            r_mem_write;
   logic            r_mem_read;
   logic [ADR-1:0]  r_mem_addr;
   logic [DATA-1:0] r_mem_din;

   logic            w_rd_busy;
   logic            w_addr_ok;
   logic            w_req_ready;
   logic            w_accept;
   logic            w_rd_launch;
   logic            w_rsp_take;
   logic            w_cs_nxt;
   logic            w_wr_nxt;
   logic            w_rd_nxt;
   logic [ADR-1:0]  w_addr_nxt;
   logic [DATA-1:0] w_din_nxt;

   ram_clear_seq #(
      .ADR      (ADR),
      .MS       (MS),
      .CLEAR_EN (CLEAR_EN)
   ) u_clear_seq (
      .clk          (clk),
      .rst_n        (rst_n),
      .o_clr_active (w_clr_active),
      .o_clr_addr   (w_clr_addr),
      .o_clr_last   (w_clr_last),
      .o_done       (w_clr_done)
   );

   // Only one read may be outstanding, including one parked on the response port.
   assign w_rd_busy  = r_rd_s1 | r_rd_s2 | r_rsp_valid;
   assign w_addr_ok  = ({1'b0, bus.req_addr} < c_MS);
   assign w_rsp_take = r_rsp_valid && bus.rsp_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_RST_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 1'b0;
      w_accept    = 1'b0;
      w_rd_launch = 1'b0;
      w_cs_nxt    = 1'b0;
      w_wr_nxt    = 1'b0;
      w_rd_nxt    = 1'b0;
      w_addr_nxt  = r_mem_addr;
      w_din_nxt   = r_mem_din;
      case (r_state)
         CLEAR: begin
            if (w_clr_active) begin
               w_cs_nxt   = 1'b1;
               w_wr_nxt   = 1'b1;
               w_addr_nxt = w_clr_addr;
               w_din_nxt  = INIT_VAL;
            end
            if (w_clr_last) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_req_ready = !w_rd_busy;
            w_accept    = bus.req_valid && w_req_ready;
            if (w_accept) begin
               w_rd_launch = !bus.req_we;
               // Out-of-range requests are accepted but never reach the RAM.
               if (w_addr_ok) begin
                  w_cs_nxt   = 1'b1;
                  w_addr_nxt = bus.req_addr;
                  if (bus.req_we) begin
                     w_wr_nxt  = 1'b1;
                     w_din_nxt = bus.req_wdata;
                  end else begin
                     w_rd_nxt  = 1'b1;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = c_RST_STATE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_cs    <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
         r_rd_s1     <= 1'b0;
         r_rd_s2     <= 1'b0;
         r_err_s1    <= 1'b0;
         r_err_s2    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_mem_cs    <= w_cs_nxt;
         r_mem_write <= w_wr_nxt;
         r_mem_read  <= w_rd_nxt;
         r_mem_addr  <= w_addr_nxt;
         r_mem_din   <= w_din_nxt;
         r_rd_s1     <= w_rd_launch;
         r_err_s1    <= w_rd_launch && !w_addr_ok;
         r_rd_s2     <= r_rd_s1;
         r_err_s2    <= r_err_s1;
         // RAM dataOut is valid one edge after the strobe; capture on the next.
         if (r_rd_s2) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_err_s2 ? '0 : bus.mem_dout;
            r_rsp_err   <= r_err_s2;
         end else if (w_rsp_take) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.init_done = w_clr_done;
   assign bus.mem_cs    = r_mem_cs;
   assign bus.mem_write = r_mem_write;
   assign bus.mem_read  = r_mem_read;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_din   = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_access_ctrl                                                       |
// | Self-checking bench: full-range instance plus a 1000-word instance       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ram_access_ctrl;
   import ram_access_pkg::*;

   localparam int ADR  = 10;
   localparam int DATA = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       err;
   } rsp_t;

   typedef struct {
      logic       we;
      logic [9:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n;
   logic rst_b_n;
   logic ram_fill;

   int n_pass  = 0;
   int n_total = 0;

   rsp_t sb[$];
   vec_t vecs[12];

   logic [DATA-1:0] mem_a [0:1023];
   logic [DATA-1:0] mem_b [0:1023];

   ram_access_ctrl_if #(.ADR(ADR), .DATA(DATA)) bus_a ();
   ram_access_ctrl_if #(.ADR(ADR), .DATA(DATA)) bus_b ();

   ram_access_ctrl #(
      .ADR(ADR), .DATA(DATA), .MS(1024), .INIT_VAL(8'h00), .CLEAR_EN(1)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_a_n),
      .bus   (bus_a)
   );

   ram_access_ctrl #(
      .ADR(ADR), .DATA(DATA), .MS(1000), .INIT_VAL(8'h00), .CLEAR_EN(1)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_b_n),
      .bus   (bus_b)
   );

   // Single-port synchronous RAM models with registered read data
   always @(posedge clk) begin
      if (ram_fill) begin
         for (int i = 0; i < 1024; i++) begin
            mem_a[i] <= 8'h5A;
            mem_b[i] <= 8'h5A;
         end
      end else begin
         if (bus_a.mem_cs && bus_a.mem_write) mem_a[bus_a.mem_addr] <= bus_a.mem_din;
         if (bus_b.mem_cs && bus_b.mem_write) mem_b[bus_b.mem_addr] <= bus_b.mem_din;
      end
      if (bus_a.mem_cs && bus_a.mem_read) bus_a.mem_dout <= mem_a[bus_a.mem_addr];
      if (bus_b.mem_cs && bus_b.mem_read) bus_b.mem_dout <= mem_b[bus_b.mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard for instance A: a handshake seen here completes on the next edge.
   always @(negedge clk) begin
      rsp_t e;
      if (bus_a.rsp_valid === 1'b1 && bus_a.rsp_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_data", 32'(bus_a.rsp_data), 32'(e.data));
            chk("rsp_err", 32'(bus_a.rsp_err), 32'(e.err));
         end
      end
   end

   task automatic req_a(input logic we, input logic [9:0] addr, input logic [7:0] d);
      int n = 0;
      bus_a.req_valid = 1'b1;
      bus_a.req_we    = we;
      bus_a.req_addr  = addr;
      bus_a.req_wdata = d;
      while (!bus_a.req_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("req_a_ready_timeout", 32'd0, 32'd1);
      tick();
      bus_a.req_valid = 1'b0;
   endtask

   task automatic req_b(input logic we, input logic [9:0] addr, input logic [7:0] d);
      int n = 0;
      bus_b.req_valid = 1'b1;
      bus_b.req_we    = we;
      bus_b.req_addr  = addr;
      bus_b.req_wdata = d;
      while (!bus_b.req_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("req_b_ready_timeout", 32'd0, 32'd1);
      tick();
      bus_b.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         chk("rsp_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   // Called right after reset is released on instance A.
   task automatic clear_check_a();
      int bad_str = 0;
      int bad_rdy = 0;
      int done_k  = 0;
      for (int k = 1; k <= 1100 && done_k == 0; k++) begin
         tick();
         if (k <= 1024) begin
            if (!(bus_a.mem_cs && bus_a.mem_write && !bus_a.mem_read &&
                  bus_a.mem_addr == 10'(k - 1) && bus_a.mem_din == 8'h00)) bad_str++;
         end
         if (k < 1024 && bus_a.req_ready) bad_rdy++;
         if (bus_a.init_done) done_k = k;
      end
      chk("clear_strobes", 32'(bad_str), 32'd0);
      chk("clear_req_ready_low", 32'(bad_rdy), 32'd0);
      chk("init_done_cycle", 32'(done_k), 32'd1025);
      chk("post_clear_idle", 32'(bus_a.mem_cs), 32'd0);
      chk("post_clear_ready", 32'(bus_a.req_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      int k;

      vecs[0]  = '{1'b1, 10'h3FF, 8'hA5, 8'h00};
      vecs[1]  = '{1'b0, 10'h3FF, 8'h00, 8'hA5};
      vecs[2]  = '{1'b1, 10'h010, 8'h3C, 8'h00};
      vecs[3]  = '{1'b0, 10'h010, 8'h00, 8'h3C};
      vecs[4]  = '{1'b0, 10'h123, 8'h00, 8'h00};
      vecs[5]  = '{1'b1, 10'h200, 8'hFF, 8'h00};
      vecs[6]  = '{1'b0, 10'h200, 8'h00, 8'hFF};
      vecs[7]  = '{1'b1, 10'h000, 8'h11, 8'h00};
      vecs[8]  = '{1'b1, 10'h001, 8'h22, 8'h00};
      vecs[9]  = '{1'b0, 10'h000, 8'h00, 8'h11};
      vecs[10] = '{1'b0, 10'h001, 8'h00, 8'h22};
      vecs[11] = '{1'b0, 10'h3FE, 8'h00, 8'h00};

      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      ram_fill = 1'b1;
      bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
      bus_a.req_wdata = '0;   bus_a.rsp_ready = 1'b1;
      bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
      bus_b.req_wdata = '0;   bus_b.rsp_ready = 1'b1;
      tick(); tick(); tick();
      ram_fill = 1'b0;

      chk("rst_strobes", 32'({bus_a.mem_cs, bus_a.mem_write, bus_a.mem_read}), 32'd0);
      chk("rst_addr_din", 32'({bus_a.mem_addr, bus_a.mem_din}), 32'd0);
      chk("rst_rsp", 32'({bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_data}), 32'd0);
      chk("rst_init_done", 32'(bus_a.init_done), 32'd0);
      chk("rst_req_ready", 32'(bus_a.req_ready), 32'd0);

      rst_a_n = 1'b1;
      clear_check_a();
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem_a[i] !== 8'h00) bad++;
      chk("ram_cleared", 32'(bad), 32'd0);

      // Table-driven traffic with the response port always ready
      for (int i = 0; i < 12; i++) begin
         req_a(vecs[i].we, vecs[i].addr, vecs[i].wdata);
         if (!vecs[i].we) begin
            sb.push_back('{data: vecs[i].exp, err: 1'b0});
            drain();
         end
      end

      // Read latency and strobe shape
      req_a(1'b0, 10'h3FF, 8'h00);
      sb.push_back('{data: 8'hA5, err: 1'b0});
      chk("rd_strobe", 32'({bus_a.mem_cs, bus_a.mem_read, bus_a.mem_write}), 32'b110);
      chk("rd_addr", 32'(bus_a.mem_addr), 32'h3FF);
      chk("rd_busy_ready", 32'(bus_a.req_ready), 32'd0);
      tick();
      chk("rsp_not_yet", 32'(bus_a.rsp_valid), 32'd0);
      chk("rd_strobe_single", 32'(bus_a.mem_cs), 32'd0);
      tick();
      chk("rsp_latency2", 32'(bus_a.rsp_valid), 32'd1);
      tick();
      chk("rsp_cleared", 32'(bus_a.rsp_valid), 32'd0);
      chk("ready_returns", 32'(bus_a.req_ready), 32'd1);

      // Backpressure on the response port
      bus_a.rsp_ready = 1'b0;
      req_a(1'b0, 10'h010, 8'h00);
      sb.push_back('{data: 8'h3C, err: 1'b0});
      tick(); tick();
      chk("bp_valid", 32'(bus_a.rsp_valid), 32'd1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!(bus_a.rsp_valid && bus_a.rsp_data == 8'h3C && !bus_a.rsp_err && !bus_a.req_ready)) bad++;
      end
      chk("bp_hold", 32'(bad), 32'd0);
      bus_a.rsp_ready = 1'b1;
      tick();
      chk("bp_release_valid", 32'(bus_a.rsp_valid), 32'd0);
      chk("bp_release_ready", 32'(bus_a.req_ready), 32'd1);
      drain();

      // Streaming writes, one per cycle
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         bus_a.req_valid = 1'b1;
         bus_a.req_we    = 1'b1;
         bus_a.req_addr  = 10'(i);
         bus_a.req_wdata = 8'(8'h80 + i);
         if (!bus_a.req_ready) bad++;
         tick();
         if (!(bus_a.mem_cs && bus_a.mem_write && !bus_a.mem_read &&
               bus_a.mem_addr == 10'(i) && bus_a.mem_din == 8'(8'h80 + i))) bad++;
      end
      bus_a.req_valid = 1'b0;
      chk("stream_wr", 32'(bad), 32'd0);
      tick();
      chk("stream_idle", 32'(bus_a.mem_cs), 32'd0);
      chk("stream_ram", 32'({mem_a[0], mem_a[1], mem_a[2], mem_a[3]}), 32'h80818283);
      req_a(1'b0, 10'h003, 8'h00);
      sb.push_back('{data: 8'h83, err: 1'b0});
      drain();

      // Reset one cycle after a read is accepted
      req_a(1'b0, 10'h002, 8'h00);
      rst_a_n = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus_a.rsp_valid || bus_a.mem_cs || bus_a.init_done) bad++;
      end
      chk("rst_mid_rd_quiet", 32'(bad), 32'd0);
      rst_a_n = 1'b1;
      clear_check_a();
      chk("rst_mid_rd_no_rsp", 32'(sb.size()), 32'd0);
      req_a(1'b0, 10'h003, 8'h00);
      sb.push_back('{data: 8'h00, err: 1'b0});
      drain();

      // Instance B: MS=1000, out-of-range handling
      rst_b_n = 1'b1;
      bad = 0;
      k = 0;
      for (int i = 1; i <= 1100 && k == 0; i++) begin
         tick();
         if (i <= 1000 && !(bus_b.mem_cs && bus_b.mem_write && bus_b.mem_addr == 10'(i - 1))) bad++;
         if (bus_b.init_done) k = i;
      end
      chk("b_clear_strobes", 32'(bad), 32'd0);
      chk("b_init_done_cycle", 32'(k), 32'd1001);

      req_b(1'b0, 10'd1000, 8'h00);
      chk("oor_rd_no_cs", 32'(bus_b.mem_cs), 32'd0);
      tick();
      chk("oor_rd_no_cs2", 32'(bus_b.mem_cs), 32'd0);
      chk("oor_rd_pending", 32'(bus_b.rsp_valid), 32'd0);
      tick();
      chk("oor_rsp", 32'({bus_b.rsp_valid, bus_b.rsp_err, bus_b.rsp_data}), 32'h300);
      tick();
      chk("oor_rsp_done", 32'(bus_b.rsp_valid), 32'd0);

      req_b(1'b1, 10'd1001, 8'h77);
      chk("oor_wr_no_cs", 32'(bus_b.mem_cs), 32'd0);
      chk("oor_wr_ready", 32'(bus_b.req_ready), 32'd1);

      req_b(1'b0, 10'd999, 8'h00);
      chk("b_edge_rd_strobe", 32'({bus_b.mem_cs, bus_b.mem_read, bus_b.mem_addr}), 32'({2'b11, 10'd999}));
      tick(); tick();
      chk("b_edge_rsp", 32'({bus_b.rsp_valid, bus_b.rsp_err, bus_b.rsp_data}), 32'h200);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
